// File: rtl/fetch_pc_ifid_stage.sv
// fetch_pc_ifid_stage
//   Program counter plus IF/ID pipeline register. Fetches from an external
//   combinational instruction memory at imem_addr (== pc) and latches the word
//   into IF/ID. The next PC comes from the jr mux (next_pc_in). The hazard unit
//   stalls via pc_write=0. The branch/jump/jr decision flushes via redirect.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   next_pc_in[31:0]    selected next PC, word-aligned on load
//   redirect            taken branch/jump/jr; inserts one IF/ID bubble
//   pc_write            0 = stall (PC and IF/ID hold, redirect ignored)
//   imem_rdata[31:0]    instruction at imem_addr, same cycle
//   imem_addr[31:0]     fetch address (pc register only)
//   pc, pc_plus_4       current PC and PC+4 (mod 2^32)
//   ifid_instr, ifid_pc_plus_4, ifid_valid   IF/ID register contents
//   fetch_state[1:0]    0 BOOT, 1 RUN, 2 STALL, 3 FLUSH
//   misalign_err        sticky, set when a misaligned next_pc_in is loaded
//   stall_count, flush_count   saturating event counters
module fetch_pc_ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      next_pc_in,
    input  logic             redirect,
    input  logic             pc_write,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus_4,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc_plus_4,
    output logic             ifid_valid,
    output logic [1:0]       fetch_state,
    output logic             misalign_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q, pp4_q;
    logic             valid_q;
    logic             mis_q;
    logic [CNT_W-1:0] stall_q, flush_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= BOOT;
        else       state_q <= state_d;
    end

    // Next state: purely a function of this cycle's control inputs
    always_comb begin
        state_d = RUN;
        if (!pc_write)     state_d = STALL;
        else if (redirect) state_d = FLUSH;
    end

    // Output decode
    always_comb begin
        fetch_state = state_q;
    end

    // PC, IF/ID and status datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pp4_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else if (!pc_write) begin
            // Redirect is deliberately dropped here; the hazard unit re-presents it.
            if (stall_q != '1) stall_q <= stall_q + CNT_ONE;
        end else begin
            pc_q <= {next_pc_in[31:2], 2'b00};
            if (next_pc_in[1:0] != 2'b00) mis_q <= 1'b1;
            if (redirect) begin
                instr_q <= '0;
                pp4_q   <= '0;
                valid_q <= 1'b0;
                if (flush_q != '1) flush_q <= flush_q + CNT_ONE;
            end else begin
                instr_q <= imem_rdata;
                pp4_q   <= pc_q + 32'd4;
                valid_q <= 1'b1;
            end
        end
    end

    assign pc             = pc_q;
    assign imem_addr      = pc_q;
    assign pc_plus_4      = pc_q + 32'd4;
    assign ifid_instr     = instr_q;
    assign ifid_pc_plus_4 = pp4_q;
    assign ifid_valid     = valid_q;
    assign misalign_err   = mis_q;
    assign stall_count    = stall_q;
    assign flush_count    = flush_q;

endmodule

// File: tb/tb_fetch_pc_ifid_stage.sv
module tb_fetch_pc_ifid_stage;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   next_pc_in;
    logic          redirect;
    logic          pc_write;
    logic [31:0]   imem_rdata;
    logic [31:0]   imem_addr;
    logic [31:0]   pc;
    logic [31:0]   pc_plus_4;
    logic [31:0]   ifid_instr;
    logic [31:0]   ifid_pc_plus_4;
    logic          ifid_valid;
    logic [1:0]    fetch_state;
    logic          misalign_err;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    fetch_pc_ifid_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .next_pc_in(next_pc_in), .redirect(redirect),
        .pc_write(pc_write), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
        .pc(pc), .pc_plus_4(pc_plus_4), .ifid_instr(ifid_instr),
        .ifid_pc_plus_4(ifid_pc_plus_4), .ifid_valid(ifid_valid),
        .fetch_state(fetch_state), .misalign_err(misalign_err),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Instruction memory model: word = address ^ A5A5_0000
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   pp4;
        logic [31:0]   instr;
        logic [31:0]   ipp4;
        logic          valid;
        logic [1:0]    st;
        logic          mis;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every post-edge sample is a DUT output; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",             pc,                      e.pc);
                chk("imem_addr",      imem_addr,               e.pc);
                chk("pc_plus_4",      pc_plus_4,               e.pp4);
                chk("ifid_instr",     ifid_instr,              e.instr);
                chk("ifid_pc_plus_4", ifid_pc_plus_4,          e.ipp4);
                chk("ifid_valid",     {31'd0, ifid_valid},     {31'd0, e.valid});
                chk("fetch_state",    {30'd0, fetch_state},    {30'd0, e.st});
                chk("misalign_err",   {31'd0, misalign_err},   {31'd0, e.mis});
                chk("stall_count",    {28'd0, stall_count},    {28'd0, e.sc});
                chk("flush_count",    {28'd0, flush_count},    {28'd0, e.fc});
            end
        end
    end

    // Apply one cycle of inputs and queue the hand-computed post-edge state.
    task automatic step(
        input logic rst, input logic pw, input logic rd, input logic [31:0] npc,
        input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_ipp4,
        input logic e_valid, input logic [1:0] e_st, input logic e_mis,
        input logic [CW-1:0] e_sc, input logic [CW-1:0] e_fc);
        exp_t e;
        reset = rst; pc_write = pw; redirect = rd; next_pc_in = npc;
        e.pc = e_pc; e.pp4 = e_pc + 32'd4; e.instr = e_instr; e.ipp4 = e_ipp4;
        e.valid = e_valid; e.st = e_st; e.mis = e_mis; e.sc = e_sc; e.fc = e_fc;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_FLUSH = 2'd3;

    initial begin
        int guard;
        reset = 1'b1; pc_write = 1'b1; redirect = 1'b0; next_pc_in = '0;
        #2;
        //    rst pw rd npc            pc            instr          ipp4          v  state   mis sc  fc
        step(1, 1, 0, 32'h0,         32'h0,        32'h0,         32'h0,        0, S_BOOT,  0, 0,  0);
        // sequential fetch
        step(0, 1, 0, 32'h4,         32'h4,        32'hA5A5_0000, 32'h4,        1, S_RUN,   0, 0,  0);
        step(0, 1, 0, 32'h8,         32'h8,        32'hA5A5_0004, 32'h8,        1, S_RUN,   0, 0,  0);
        // two-cycle stall at pc 8
        step(0, 0, 0, 32'hC,         32'h8,        32'hA5A5_0004, 32'h8,        1, S_STALL, 0, 1,  0);
        step(0, 0, 0, 32'hC,         32'h8,        32'hA5A5_0004, 32'h8,        1, S_STALL, 0, 2,  0);
        step(0, 1, 0, 32'hC,         32'hC,        32'hA5A5_0008, 32'hC,        1, S_RUN,   0, 2,  0);
        // taken branch to 0x40 -> one bubble, then target instruction
        step(0, 1, 1, 32'h40,        32'h40,       32'h0,         32'h0,        0, S_FLUSH, 0, 2,  1);
        step(0, 1, 0, 32'h44,        32'h44,       32'hA5A5_0040, 32'h44,       1, S_RUN,   0, 2,  1);
        // stall with redirect: redirect ignored, then re-presented
        step(0, 0, 1, 32'h80,        32'h44,       32'hA5A5_0040, 32'h44,       1, S_STALL, 0, 3,  1);
        step(0, 1, 1, 32'h80,        32'h80,       32'h0,         32'h0,        0, S_FLUSH, 0, 3,  2);
        // misaligned jr target, sticky error
        step(0, 1, 0, 32'h102,       32'h100,      32'hA5A5_0080, 32'h84,       1, S_RUN,   1, 3,  2);
        step(0, 1, 0, 32'h104,       32'h104,      32'hA5A5_0100, 32'h104,      1, S_RUN,   1, 3,  2);
        step(0, 1, 0, 32'h108,       32'h108,      32'hA5A5_0104, 32'h108,      1, S_RUN,   1, 3,  2);
        step(0, 1, 0, 32'h10C,       32'h10C,      32'hA5A5_0108, 32'h10C,      1, S_RUN,   1, 3,  2);
        step(0, 1, 0, 32'h110,       32'h110,      32'hA5A5_010C, 32'h110,      1, S_RUN,   1, 3,  2);
        step(0, 1, 0, 32'h114,       32'h114,      32'hA5A5_0110, 32'h114,      1, S_RUN,   1, 3,  2);
        // reset clears everything
        step(1, 1, 0, 32'h118,       32'h0,        32'h0,         32'h0,        0, S_BOOT,  0, 0,  0);
        // 20 stall cycles: counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 32'h4,     32'h0,        32'h0,         32'h0,        0, S_STALL, 0,
                 (i < 15) ? CW'(i + 1) : 4'hF, 0);
        end
        // load top word: pc_plus_4 wraps to 0, no error
        step(0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hA5A5_0000, 32'h4,       1, S_RUN,   0, 15, 0);
        step(0, 1, 1, 32'h200,       32'h200,      32'h0,         32'h0,        0, S_FLUSH, 0, 15, 1);
        // reset mid-flush, with stall and redirect both asserted
        step(1, 0, 1, 32'h300,       32'h0,        32'h0,         32'h0,        0, S_BOOT,  0, 0,  0);
        // out of reset into a stall: counter restarts from zero
        step(0, 0, 0, 32'h4,         32'h0,        32'h0,         32'h0,        0, S_STALL, 0, 1,  0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ifid_stage.md
Name: fetch_pc_ifid_stage

Overview:
Owns the program counter and the IF/ID pipeline register. It drives PC+4 into the branch mux, fetches from the external instruction memory, and latches the result into IF/ID. It loads the next PC from the output of the jr mux. Stalls come from the hazard unit, and flushes come from the branch/jump/jr decision.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the saturating stall and flush counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
next_pc_in  input  32  selected next PC (jr mux output)
redirect  input  1  branch taken, jump or jr resolved in ID this cycle; flush IF/ID
pc_write  input  1  hazard unit PC/IF-ID enable; 0 = stall
imem_rdata  input  32  instruction word at imem_addr, combinational same cycle
imem_addr  output  32  equals pc
pc  output  32  current PC register
pc_plus_4  output  32  pc + 4, combinational, feeds branch mux input 1
ifid_instr  output  32  IF/ID instruction
ifid_pc_plus_4  output  32  IF/ID copy of PC+4 (used for BTA and jal link)
ifid_valid  output  1  IF/ID holds a real instruction
fetch_state  output  2  0 BOOT, 1 RUN, 2 STALL, 3 FLUSH
misalign_err  output  1  sticky; set when next_pc_in[1:0] != 0 is loaded
stall_count  output  CNT_W  saturating count of stall cycles
flush_count  output  CNT_W  saturating count of flush cycles

Behaviour:
- Reset (synchronous, highest priority) sets:
  - pc = RESET_PC
  - ifid_instr = 0 (sll $0 NOP), ifid_pc_plus_4 = 0, ifid_valid = 0
  - fetch_state = BOOT, misalign_err = 0, counters = 0
- pc_plus_4 = pc + 4, mod 2^32; wrap 32'hFFFF_FFFC -> 0 is legal and not an error.
- Per-edge priority, out of reset:
  1. pc_write = 0 (stall):
     - pc and all IF/ID fields hold
     - redirect is ignored; the hazard unit re-presents it after the stall
     - stall_count += 1
     - state -> STALL
  2. pc_write = 1 and redirect = 1:
     - pc <= {next_pc_in[31:2], 2'b00}
     - IF/ID <= bubble (instr 0, pc_plus_4 0, valid 0)
     - flush_count += 1
     - state -> FLUSH
  3. Otherwise:
     - pc <= {next_pc_in[31:2], 2'b00}
     - ifid_instr <= imem_rdata, ifid_pc_plus_4 <= pc_plus_4, ifid_valid <= 1
     - state -> RUN
- Misalignment: when the pc is loaded (case 2 or 3) with next_pc_in[1:0] != 0, misalign_err <= 1. It stays set until reset. The loaded pc is still forced word-aligned.
- State transitions: BOOT is held for exactly the reset cycle. Every later state is set by the priority rules above from that cycle's inputs. Any state can reach any of RUN, STALL or FLUSH.
- Counters saturate at all-ones and do not wrap. The BOOT cycle increments neither counter.
- Latency:
  - instruction at pc appears on ifid_instr 1 cycle later
  - redirect target appears on pc 1 cycle later; its instruction appears on IF/ID 2 cycles later
  - exactly one bubble per taken redirect
- Reset asserted mid-stall or mid-flush: the next edge gives reset values regardless of pc_write or redirect.
- No combinational path from redirect or pc_write to imem_addr. imem_addr depends only on the pc register.

Test Plan:
- Reset then sequential fetch: reset 1 cycle, RESET_PC = 0; next_pc_in tied to pc_plus_4; imem returns addr ^ 32'hA5A5_0000 -> pc 0, 4, 8; ifid_instr 32'hA5A5_0000 then 32'hA5A5_0004; ifid_pc_plus_4 4, 8; ifid_valid 1 from cycle 2; fetch_state RUN.
- Stall: pc_write = 0 for 2 cycles at pc = 8 -> pc holds 8, IF/ID holds the instr from addr 4, stall_count = 2, state STALL; pc resumes at 12 after release.
- Taken branch: redirect = 1, next_pc_in = 32'h40 at pc = 12 -> pc = 32'h40, ifid_valid = 0, ifid_instr = 0, flush_count = 1, state FLUSH; the next cycle ifid_instr = 32'hA5A5_0040.
- Stall and redirect together: pc_write = 0, redirect = 1 -> pc holds, flush_count unchanged, stall_count += 1.
- Misaligned jr: next_pc_in = 32'h0000_0102 -> pc = 32'h100, misalign_err = 1 and it stays 1 through 5 more cycles until reset.
- Saturation and wrap: with CNT_W = 4, hold pc_write = 0 for 20 cycles -> stall_count = 15. Then load next_pc_in = 32'hFFFF_FFFC -> pc_plus_4 = 0, misalign_err unchanged. Then reset mid-flush -> all outputs return to reset values on the next edge.
